// File: rtl/mips_pipe_ctrl.sv
// mips_pipe_ctrl: pipeline sequencer for the 5-stage MIPS core.
// Owns the fetch PC, the per-stage valid bits, load-use stall detection,
// taken-branch flush and the RUN/DRAIN/HALTED halt state machine.
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   id_rs/id_rt/id_uses_rs/rt      source operands of the instruction in ID
//   ex_mem_read, ex_rt             load in EX and its destination register
//   mem_branch_taken/target        branch resolved taken in MEM, redirect PC
//   halt_req, resume               stop-and-drain request, restart fetching
//   pc                             fetch address
//   *_en, *_flush                  stage register load enables / bubble inserts
//   v_id..v_wb                     stage valid bits
//   halted                         pipeline empty and stopped
//   stall_cnt, flush_cnt           saturating event counters
module mips_pipe_ctrl #(
  parameter int unsigned PC_W     = 8,
  parameter int unsigned PC_STEP  = 1,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic             mem_branch_taken,
  input  logic [PC_W-1:0]  mem_branch_target,
  input  logic             halt_req,
  input  logic             resume,
  output logic [PC_W-1:0]  pc,
  output logic             if_id_en,
  output logic             id_ex_en,
  output logic             ex_mem_en,
  output logic             mem_wb_en,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             v_id,
  output logic             v_ex,
  output logic             v_mem,
  output logic             v_wb,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t state;
  logic   br;
  logic   hz;
  logic   stall;
  logic   fetch;

  // Qualified events; a branch in MEM overrides a load-use stall.
  always_comb begin
    br    = 1'b0;
    hz    = 1'b0;
    stall = 1'b0;
    fetch = 1'b0;
    br    = mem_branch_taken & v_mem;
    hz    = v_ex & ex_mem_read & (ex_rt != 5'd0) & v_id &
            ((id_uses_rs & (id_rs == ex_rt)) | (id_uses_rt & (id_rt == ex_rt)));
    stall = hz & ~br;
    fetch = (state == RUN) & ~br & ~stall;
  end

  assign if_id_en     = ~stall;
  assign id_ex_en     = 1'b1;
  assign ex_mem_en    = 1'b1;
  assign mem_wb_en    = 1'b1;
  assign if_id_flush  = br | (state != RUN);
  assign id_ex_flush  = br | stall;
  assign ex_mem_flush = br;
  assign halted       = (state == HALTED);

  // State machine, PC, valid bits and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      pc        <= PC_W'(RESET_PC);
      v_id      <= 1'b0;
      v_ex      <= 1'b0;
      v_mem     <= 1'b0;
      v_wb      <= 1'b0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      case (state)
        RUN:     if (halt_req) state <= DRAIN;
        DRAIN:   if (!(v_id | v_ex | v_mem | v_wb)) state <= HALTED;
        HALTED:  if (resume) state <= RUN;
        default: state <= RUN;
      endcase

      // Redirect wins over fetch in every state, so a branch during DRAIN
      // still leaves the PC at the target for resume.
      if (br)         pc <= mem_branch_target;
      else if (fetch) pc <= pc + PC_W'(PC_STEP);

      if (br)         v_id <= 1'b0;
      else if (!stall) v_id <= fetch;
      v_ex  <= (br | stall) ? 1'b0 : v_id;
      v_mem <= br ? 1'b0 : v_ex;
      v_wb  <= v_mem;

      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
      if (br && (flush_cnt != '1))    flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_mips_pipe_ctrl.sv
// Testbench for mips_pipe_ctrl: two instances (8-bit PC / 16-bit counters and
// 4-bit PC / 3-bit counters) driven by the same stimulus and compared every
// cycle against a behavioural pipeline model.
module tb_mips_pipe_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] id_rs, id_rt, ex_rt;
  logic       id_uses_rs, id_uses_rt, ex_mem_read;
  logic       mem_branch_taken;
  logic [7:0] tgt;
  logic       halt_req, resume;

  always #5 clk = ~clk;

  logic [7:0]  pc0;
  logic [3:0]  pc1;
  logic [15:0] sc0, fc0;
  logic [2:0]  sc1, fc1;
  logic [3:0]  en0, en1, val0, val1;
  logic [2:0]  fl0, fl1;
  logic        h0, h1;

  mips_pipe_ctrl #(.PC_W(8), .PC_STEP(1), .RESET_PC(8'h10), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .mem_branch_taken(mem_branch_taken), .mem_branch_target(tgt),
    .halt_req(halt_req), .resume(resume), .pc(pc0),
    .if_id_en(en0[3]), .id_ex_en(en0[2]), .ex_mem_en(en0[1]), .mem_wb_en(en0[0]),
    .if_id_flush(fl0[2]), .id_ex_flush(fl0[1]), .ex_mem_flush(fl0[0]),
    .v_id(val0[3]), .v_ex(val0[2]), .v_mem(val0[1]), .v_wb(val0[0]),
    .halted(h0), .stall_cnt(sc0), .flush_cnt(fc0)
  );

  mips_pipe_ctrl #(.PC_W(4), .PC_STEP(1), .RESET_PC(4'hE), .CNT_W(3)) dut1 (
    .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt),
    .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .ex_mem_read(ex_mem_read), .ex_rt(ex_rt),
    .mem_branch_taken(mem_branch_taken), .mem_branch_target(tgt[3:0]),
    .halt_req(halt_req), .resume(resume), .pc(pc1),
    .if_id_en(en1[3]), .id_ex_en(en1[2]), .ex_mem_en(en1[1]), .mem_wb_en(en1[0]),
    .if_id_flush(fl1[2]), .id_ex_flush(fl1[1]), .ex_mem_flush(fl1[0]),
    .v_id(val1[3]), .v_ex(val1[2]), .v_mem(val1[1]), .v_wb(val1[0]),
    .halted(h1), .stall_cnt(sc1), .flush_cnt(fc1)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: one slot per pipeline stage (0=ID .. 3=WB) holding a
  // valid flag, plus mode 0=run, 1=drain, 2=halted.
  localparam int unsigned PC_MASK [2] = '{255, 15};
  localparam int unsigned CNT_MAX [2] = '{65535, 7};
  localparam int unsigned RST_PC  [2] = '{16, 14};

  int unsigned m_pc [2];
  int unsigned m_sc [2];
  int unsigned m_fc [2];
  int          m_mode [2];
  bit          slot [2][4];
  bit          first = 1'b1;

  task automatic model_reset(input int k);
    m_pc[k] = RST_PC[k];
    m_sc[k] = 0;
    m_fc[k] = 0;
    m_mode[k] = 0;
    for (int s = 0; s < 4; s++) slot[k][s] = 1'b0;
  endtask

  // One clock: check outputs mid-cycle, then advance the model at the edge.
  task automatic cyc();
    bit br [2], stall [2], fetch [2];
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bit hz;
      hz = slot[k][1] && ex_mem_read && ex_rt != 0 && slot[k][0] &&
           ((id_uses_rs && id_rs == ex_rt) || (id_uses_rt && id_rt == ex_rt));
      br[k]    = mem_branch_taken && slot[k][2];
      stall[k] = hz && !br[k];
      fetch[k] = m_mode[k] == 0 && !br[k] && !stall[k];
      if (!first) begin
        logic [31:0] g_pc, g_sc, g_fc;
        logic [3:0]  g_en, g_v;
        logic [2:0]  g_fl;
        logic        g_h;
        if (k == 0) begin
          g_pc = 32'(pc0); g_sc = 32'(sc0); g_fc = 32'(fc0);
          g_en = en0; g_v = val0; g_fl = fl0; g_h = h0;
        end else begin
          g_pc = 32'(pc1); g_sc = 32'(sc1); g_fc = 32'(fc1);
          g_en = en1; g_v = val1; g_fl = fl1; g_h = h1;
        end
        check(k == 0 ? "pc0" : "pc1", g_pc, m_pc[k]);
        check(k == 0 ? "en0" : "en1", 32'(g_en), {28'd0, !stall[k], 3'b111});
        check(k == 0 ? "flush0" : "flush1", 32'(g_fl),
              {29'd0, br[k] || m_mode[k] != 0, br[k] || stall[k], br[k]});
        check(k == 0 ? "valid0" : "valid1", 32'(g_v),
              {28'd0, slot[k][0], slot[k][1], slot[k][2], slot[k][3]});
        check(k == 0 ? "halted0" : "halted1", 32'(g_h), 32'(m_mode[k] == 2));
        check(k == 0 ? "stall_cnt0" : "stall_cnt1", g_sc, m_sc[k]);
        check(k == 0 ? "flush_cnt0" : "flush_cnt1", g_fc, m_fc[k]);
      end
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        model_reset(k);
      end else begin
        bit empty;
        empty = !(slot[k][0] || slot[k][1] || slot[k][2] || slot[k][3]);
        if (m_mode[k] == 0 && halt_req)      m_mode[k] = 1;
        else if (m_mode[k] == 1 && empty)    m_mode[k] = 2;
        else if (m_mode[k] == 2 && resume)   m_mode[k] = 0;
        if (br[k])         m_pc[k] = 32'(tgt) & PC_MASK[k];
        else if (fetch[k]) m_pc[k] = (m_pc[k] + 1) & PC_MASK[k];
        slot[k][3] = slot[k][2];
        slot[k][2] = br[k] ? 1'b0 : slot[k][1];
        slot[k][1] = (br[k] || stall[k]) ? 1'b0 : slot[k][0];
        slot[k][0] = br[k] ? 1'b0 : (stall[k] ? slot[k][0] : fetch[k]);
        if (stall[k] && m_sc[k] < CNT_MAX[k]) m_sc[k]++;
        if (br[k] && m_fc[k] < CNT_MAX[k])    m_fc[k]++;
      end
    end
    first = 1'b0;
    #1;
  endtask

  task automatic quiet();
    reset = 1'b0; ex_mem_read = 1'b0; ex_rt = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
    id_uses_rs = 1'b0; id_uses_rt = 1'b0; mem_branch_taken = 1'b0; tgt = 8'd0;
    halt_req = 1'b0; resume = 1'b0;
  endtask

  initial begin
    model_reset(0);
    model_reset(1);
    quiet();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;

    // Free-running fill: pc counts up from 0x10, if_id_en stays high.
    for (int i = 0; i < 6; i++) begin
      #1;
      check("pc_seq", 32'(pc0), 32'(8'h10 + i));
      check("fill_en", 32'(en0[3]), 32'd1);
      cyc();
    end
    #1;
    check("v_wb_filled", 32'(val0[0]), 32'd1);

    // Load-use hazard: one stall cycle, then clear.
    ex_mem_read = 1'b1; ex_rt = 5'd5; id_rs = 5'd5; id_uses_rs = 1'b1;
    #1;
    check("lu_if_id_en", 32'(en0[3]), 32'd0);
    check("lu_id_ex_flush", 32'(fl0[1]), 32'd1);
    cyc();
    quiet();
    cyc();
    // Same pattern against r0: no stall.
    ex_mem_read = 1'b1; ex_rt = 5'd0; id_rs = 5'd0; id_uses_rs = 1'b1;
    #1;
    check("r0_no_stall", 32'(en0[3]), 32'd1);
    cyc();
    quiet();
    cyc();
    cyc();

    // Branch together with a load-use hazard: branch wins.
    ex_mem_read = 1'b1; ex_rt = 5'd7; id_rt = 5'd7; id_uses_rt = 1'b1;
    mem_branch_taken = 1'b1; tgt = 8'h40;
    cyc();
    quiet();
    #1;
    check("br_pc", 32'(pc0), 32'h40);
    check("br_stall_cnt", 32'(sc0), 32'd1);
    for (int i = 0; i < 5; i++) cyc();

    // Halt with a full pipeline, re-request halt while draining, then resume.
    halt_req = 1'b1;
    cyc();
    begin
      int n = 1;
      while (!h0 && n < 8) begin
        halt_req = (n == 2);
        cyc();
        n++;
      end
      check("halt_within_bound", 32'(h0 && n <= 6), 32'd1);
    end
    quiet();
    cyc();
    cyc();
    resume = 1'b1;
    cyc();
    resume = 1'b0;
    cyc();

    // Randomized traffic, with occasional mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom_range(0, 299) == 0);
      ex_mem_read      = 1'($urandom_range(0, 1));
      ex_rt            = 5'($urandom_range(0, 3));
      id_rs            = 5'($urandom_range(0, 3));
      id_rt            = 5'($urandom_range(0, 3));
      id_uses_rs       = 1'($urandom_range(0, 1));
      id_uses_rt       = 1'($urandom_range(0, 1));
      mem_branch_taken = ($urandom_range(0, 9) == 0);
      tgt              = 8'($urandom);
      halt_req         = ($urandom_range(0, 39) == 0);
      resume           = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
